// File: rtl/xaui_tx_serializer.sv
`default_nettype none
// ============================================================================
// xaui_tx_serializer : four-lane 10b symbol FIFO feeding MSB-first serial lanes,
//                      with K28.5 fill at start-up and whenever no data is queued
// Revision: 1.0 - initial release
// ============================================================================
module xaui_tx_serializer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int PREAMBLE_COMMAS = 4
) (
  input  logic        xaui_clk,
  input  logic        reset,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [39:0] sym_data,
  output logic [3:0]  XAUI_TX_P,
  output logic [3:0]  XAUI_TX_N,
  output logic        sync_done,
  output logic [15:0] sym_count,
  output logic [3:0]  rd_pos,
  output logic        disp_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PREAMBLE_COMMAS + 1);

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [9:0] K285_NEG = 10'b0011111010;
  localparam logic [9:0] K285_POS = 10'b1100000101;

  logic [3:0]    cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic          sync_done_q, sync_done_d;
  logic [15:0]   sym_count_q, sym_count_d;
  logic [3:0]    rd_q, rd_d;
  logic          disp_err_q, disp_err_d;
  logic [3:0]    tx_p_q, tx_p_d;
  logic [3:0]    tx_n_q, tx_n_d;
  logic          alive_q, alive_d;
  logic [9:0]    cur_q [4];
  logic [9:0]    cur_d [4];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [39:0]   mem_q [FIFO_DEPTH];

  logic          load;
  logic          active;
  logic          empty;
  logic          full;
  logic          pop;
  logic          bypass;
  logic          wr;
  logic          fifo_push;
  logic          fifo_pop;
  logic [39:0]   head;
  logic [9:0]    head_lane [4];
  logic [9:0]    nxt_sym [4];
  logic [3:0]    nxt_ones [4];

  function automatic logic [3:0] ones10(input logic [9:0] s);
    logic [3:0] n;
    n = 4'd0;
    for (int b = 0; b < 10; b++) n = n + {3'b000, s[b]};
    return n;
  endfunction

  assign load   = (cnt_q == 4'd9);
  assign active = (state_q == ST_ACTIVE);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // An empty FIFO can still feed a load edge directly from the input bus.
  assign pop       = load && active && (!empty || (sym_valid && alive_q));
  assign bypass    = pop && empty;
  assign sym_ready = alive_q && (!full || pop);
  assign wr        = sym_valid && sym_ready;
  assign fifo_push = wr && !bypass;
  assign fifo_pop  = pop && !empty;
  assign head      = empty ? sym_data : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    head_lane[0] = head[9:0];
    head_lane[1] = head[19:10];
    head_lane[2] = head[29:20];
    head_lane[3] = head[39:30];
  end

  always_comb begin
    cnt_d       = load ? 4'd0 : cnt_q + 4'd1;
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    sync_done_d = sync_done_q;
    sym_count_d = sym_count_q;
    disp_err_d  = disp_err_q;
    rd_d        = rd_q;
    alive_d     = 1'b1;
    wr_ptr_d    = fifo_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d    = fifo_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    for (int l = 0; l < 4; l++) begin
      cur_d[l]    = cur_q[l];
      tx_p_d[l]   = cur_q[l][4'd9 - cnt_q];
      nxt_sym[l]  = pop ? head_lane[l] : (rd_q[l] ? K285_POS : K285_NEG);
      nxt_ones[l] = ones10(nxt_sym[l]);
    end
    tx_n_d = ~tx_p_d;

    if (load) begin
      if (!active) begin
        comma_cnt_d = comma_cnt_q + CW'(1);
        if (comma_cnt_q == CW'(PREAMBLE_COMMAS - 1)) begin
          state_d     = ST_ACTIVE;
          sync_done_d = 1'b1;
        end
      end
      if (pop && sym_count_q != 16'hFFFF) sym_count_d = sym_count_q + 16'd1;
      for (int l = 0; l < 4; l++) begin
        cur_d[l] = nxt_sym[l];
        case (nxt_ones[l])
          4'd6:    rd_d[l] = 1'b1;
          4'd4:    rd_d[l] = 1'b0;
          4'd5:    rd_d[l] = rd_q[l];
          default: if (pop) disp_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      state_q     <= ST_SYNC;
      comma_cnt_q <= '0;
      sync_done_q <= 1'b0;
      sym_count_q <= 16'd0;
      rd_q        <= 4'b0000;
      disp_err_q  <= 1'b0;
      tx_p_q      <= 4'b0000;
      tx_n_q      <= 4'b1111;
      alive_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int l = 0; l < 4; l++) cur_q[l] <= 10'd0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      sync_done_q <= sync_done_d;
      sym_count_q <= sym_count_d;
      rd_q        <= rd_d;
      disp_err_q  <= disp_err_d;
      tx_p_q      <= tx_p_d;
      tx_n_q      <= tx_n_d;
      alive_q     <= alive_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cur_q       <= cur_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge xaui_clk) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= sym_data;
  end

  assign XAUI_TX_P = tx_p_q;
  assign XAUI_TX_N = tx_n_q;
  assign sync_done = sync_done_q;
  assign sym_count = sym_count_q;
  assign rd_pos    = rd_q;
  assign disp_err  = disp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xaui_tx_serializer.sv
`default_nettype none
// Directed bench: lanes are deserialized into 10-bit words aligned to the known bit phase.
module tb_xaui_tx_serializer;

  localparam logic [9:0] KN = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] A  = 10'b1010101010;
  localparam logic [9:0] B  = 10'b0101010101;
  localparam logic [9:0] C  = 10'b1110000011;
  localparam logic [9:0] D  = 10'b0001111100;
  localparam logic [9:0] E  = 10'b1100101001;
  localparam logic [9:0] F  = 10'b0110100110;
  localparam logic [9:0] G  = 10'b1001011010;
  localparam logic [9:0] H  = 10'b0011100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [39:0] sym_data = '0;
  logic [3:0]  XAUI_TX_P, XAUI_TX_N;
  logic        sync_done;
  logic [15:0] sym_count;
  logic [3:0]  rd_pos;
  logic        disp_err;

  xaui_tx_serializer #(.FIFO_DEPTH(4), .PREAMBLE_COMMAS(4)) dut (
    .xaui_clk (clk),
    .reset    (reset),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_data (sym_data),
    .XAUI_TX_P(XAUI_TX_P),
    .XAUI_TX_N(XAUI_TX_N),
    .sync_done(sync_done),
    .sym_count(sym_count),
    .rd_pos   (rd_pos),
    .disp_err (disp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Rising edges since reset release; edge e carries bit (e % 10) of symbol e/10.
  int edge_n = 0;
  always @(posedge clk or posedge reset)
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;

  logic [9:0]  sh [4];
  logic [39:0] word_a [64];
  logic [3:0]  rd_a [64];
  logic [15:0] cnt_a [64];
  logic        derr_a [64];
  logic        sync_a [64];
  int          nwords = 0;
  logic        txn_bad = 1'b0;

  // word_a[k] is the word received for symbol k; the *_a[k] status arrays are
  // sampled right after symbol k was loaded.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      nwords = 0;
      for (int l = 0; l < 4; l++) sh[l] = '0;
    end else if (edge_n > 0) begin
      if (XAUI_TX_N !== ~XAUI_TX_P) txn_bad = 1'b1;
      for (int l = 0; l < 4; l++) sh[l] = {sh[l][8:0], XAUI_TX_P[l]};
      if (edge_n % 10 == 0 && edge_n / 10 < 64) begin
        word_a[edge_n/10 - 1] = {sh[3], sh[2], sh[1], sh[0]};
        rd_a[edge_n/10]   = rd_pos;
        cnt_a[edge_n/10]  = sym_count;
        derr_a[edge_n/10] = disp_err;
        sync_a[edge_n/10] = sync_done;
        nwords = edge_n / 10;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_edge(input int e);
    int t = 0;
    while (edge_n != e && t < 3000) begin @(negedge clk); t++; end
    if (edge_n != e) chk($sformatf("timeout_edge_%0d", e), 64'(edge_n), 64'(e));
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (nwords < n && t < 3000) begin @(negedge clk); t++; end
    if (nwords < n) chk($sformatf("timeout_words_%0d", n), 64'(nwords), 64'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txp"},   64'(XAUI_TX_P), 64'h0);
    chk({tag, "_txn"},   64'(XAUI_TX_N), 64'hF);
    chk({tag, "_ready"}, 64'(sym_ready), 64'h0);
    chk({tag, "_sync"},  64'(sync_done), 64'h0);
    chk({tag, "_count"}, 64'(sym_count), 64'h0);
    chk({tag, "_rd"},    64'(rd_pos),    64'h0);
    chk({tag, "_derr"},  64'(disp_err),  64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic        push;
    logic [39:0] data;
    logic [39:0] exp_word;
    logic [3:0]  exp_rd;
    logic [15:0] exp_cnt;
    logic        exp_derr;
  } vec_t;

  vec_t        tbl [8];
  logic [39:0] grp [6];

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge_n=%0d", edge_n);
    $fatal(1);
  end

  initial begin
    // Rows land in symbols 7..14; each push hits a load edge (zero-latency path).
    tbl[0] = '{1'b1, {A, A, A, A},          {A, A, A, A},          4'b0000, 16'd1, 1'b0};
    tbl[1] = '{1'b1, {A, A, A, 10'b1111110000}, {A, A, A, 10'b1111110000}, 4'b0001, 16'd2, 1'b0};
    tbl[2] = '{1'b0, 40'd0,                 {KN, KN, KN, KP},      4'b1110, 16'd2, 1'b0};
    tbl[3] = '{1'b1, {4{10'b1111111111}},   {4{10'b1111111111}},   4'b1110, 16'd3, 1'b1};
    tbl[4] = '{1'b0, 40'd0,                 {KP, KP, KP, KN},      4'b0001, 16'd3, 1'b1};
    tbl[5] = '{1'b1, {4{10'b0000011111}},   {4{10'b0000011111}},   4'b0001, 16'd4, 1'b1};
    tbl[6] = '{1'b1, {10'b1110001000, 10'b0101010101, 10'b1100110011, 10'b0000001111},
                     {10'b1110001000, 10'b0101010101, 10'b1100110011, 10'b0000001111},
               4'b0010, 16'd5, 1'b1};
    tbl[7] = '{1'b0, 40'd0,                 {KN, KN, KP, KN},      4'b1101, 16'd5, 1'b1};

    grp[0] = {A, B, C, D};
    grp[1] = {B, C, D, E};
    grp[2] = {C, D, E, F};
    grp[3] = {D, E, F, G};
    grp[4] = {E, F, G, H};
    grp[5] = {F, G, H, A};

    // Preamble, sync timing, idle comma alternation
    do_reset();
    wait_edge(39);
    chk("sync_before_4th_load", 64'(sync_done), 64'h0);
    wait_edge(40);
    chk("sync_after_4th_load", 64'(sync_done), 64'h1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].push) begin
        wait_edge(69 + 10 * i);
        sym_valid = 1'b1;
        sym_data  = tbl[i].data;
        chk($sformatf("push_ready_%0d", i), 64'(sym_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
      end
    end
    wait_words(15);

    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("idle_comma_%0d", k), 64'(word_a[k]), (k % 2 == 1) ? 64'({4{KN}}) : 64'({4{KP}}));
      chk($sformatf("idle_rd_%0d", k), 64'(rd_a[k]), (k % 2 == 1) ? 64'hF : 64'h0);
    end
    chk("idle_count", 64'(cnt_a[6]), 64'h0);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec_word_%0d", i), 64'(word_a[7+i]), 64'(tbl[i].exp_word));
      chk($sformatf("vec_rd_%0d", i),   64'(rd_a[7+i]),   64'(tbl[i].exp_rd));
      chk($sformatf("vec_cnt_%0d", i),  64'(cnt_a[7+i]),  64'(tbl[i].exp_cnt));
      chk($sformatf("vec_derr_%0d", i), 64'(derr_a[7+i]), 64'(tbl[i].exp_derr));
    end

    // Back-to-back burst offered during the preamble
    do_reset();
    begin
      int acc = 0;
      int t = 0;
      sym_valid = 1'b1;
      sym_data  = grp[0];
      while (acc < 6 && t < 500) begin
        if (sym_ready) begin
          if (acc == 4) chk("burst_5th_accept_edge", 64'(edge_n), 64'd49);
          @(posedge clk);
          acc++;
          @(negedge clk);
          if (acc == 4) chk("burst_ready_drop", 64'(sym_ready), 64'h0);
          if (acc < 6) sym_data = grp[acc];
        end else begin
          @(negedge clk);
        end
        t++;
      end
      sym_valid = 1'b0;
      chk("burst_accepted", 64'(acc), 64'd6);
    end

    // Queue four groups, one goes on the wire, three wait behind it
    wait_edge(110);
    sym_valid = 1'b1;
    sym_data  = {4{D}};
    repeat (4) @(negedge clk);
    sym_valid = 1'b0;
    chk("queue_full_ready", 64'(sym_ready), 64'h0);
    wait_edge(124);

    for (int g = 0; g < 6; g++)
      chk($sformatf("burst_word_%0d", g), 64'(word_a[5+g]), 64'(grp[g]));
    chk("burst_count", 64'(cnt_a[10]), 64'd6);
    chk("burst_rd", 64'(rd_a[10]), 64'h0);
    chk("burst_trailing_comma", 64'(word_a[11]), 64'({4{KN}}));
    chk("queued_first_popped", 64'(cnt_a[12]), 64'd7);

    // Asynchronous reset in the middle of a data symbol
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_words(7);
    chk("restart_comma_1", 64'(word_a[1]), 64'({4{KN}}));
    chk("restart_comma_5", 64'(word_a[5]), 64'({4{KN}}));
    chk("restart_comma_6", 64'(word_a[6]), 64'({4{KP}}));
    chk("restart_no_data", 64'(cnt_a[6]), 64'h0);
    chk("restart_sync", 64'(sync_a[6]), 64'h1);

    chk("txn_complement", 64'(txn_bad), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
